// File: rtl/mux_gate_pkg.sv
// Shared types for the mux-gate logic unit: opcode and FSM state encodings.
package mux_gate_pkg;

    typedef enum logic [2:0] {
        OP_AND    = 3'b000,
        OP_OR     = 3'b001,
        OP_XOR    = 3'b010,
        OP_XNOR   = 3'b011,
        OP_NAND   = 3'b100,
        OP_NOR    = 3'b101,
        OP_PASS_A = 3'b110,
        OP_PASS_B = 3'b111
    } op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

endpackage

// File: rtl/mux_gate_cell.sv
// One-bit gate cell: operand a steers a 2:1 mux between two op-dependent
// functions of b, so every opcode reduces to a ? hi : lo.
module mux_gate_cell
    import mux_gate_pkg::*;
(
    input  logic a,
    input  logic b,
    input  op_t  op,
    output logic y
);

    logic hi;
    logic lo;

    always_comb begin
        // NOTE: defaults before the case keep every path assigned, so no latch is inferred.
        hi = 1'b0;
        lo = 1'b0;
        case (op)
            OP_AND:    begin hi = b;    lo = 1'b0; end
            OP_OR:     begin hi = 1'b1; lo = b;    end
            OP_XOR:    begin hi = ~b;   lo = b;    end
            OP_XNOR:   begin hi = b;    lo = ~b;   end
            OP_NAND:   begin hi = ~b;   lo = 1'b1; end
            OP_NOR:    begin hi = 1'b0; lo = ~b;   end
            OP_PASS_A: begin hi = 1'b1; lo = 1'b0; end
            OP_PASS_B: begin hi = b;    lo = b;    end
        endcase
        y = a ? hi : lo;
    end

endmodule

// File: rtl/mux_gate_unit.sv
// Stream bitwise engine with single-beat ops and multi-beat accumulate bursts.
// Optional parity output out_par is enabled by defining MUX_GATE_PARITY_EN.
module mux_gate_unit
    import mux_gate_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int MAX_BEATS = 16,
    localparam int CW        = $clog2(MAX_BEATS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             accum,
    input  logic             last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             out_err,
`ifdef MUX_GATE_PARITY_EN
    output logic             out_par,
`endif
    output logic [CW-1:0]    out_beats
);

    state_t           state_q;
    op_t              op_q;
    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] y_q;
    logic             out_valid_q;
    logic             out_err_q;
    logic [CW-1:0]    out_beats_q;

    logic [WIDTH-1:0] opnd_d;
    logic [WIDTH-1:0] fold_d;
    logic [CW-1:0]    cnt_d;
    op_t              op_d;
    logic             in_fire;
    logic             out_fire;
    logic             burst_end;

    assign in_ready  = !out_valid_q || out_ready;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready;

    // In ACC the running accumulator replaces operand A and the latched op wins.
    assign opnd_d    = (state_q == ST_IDLE) ? a : acc_q;
    assign op_d      = (state_q == ST_IDLE) ? op_t'(op) : op_q;
    assign cnt_d     = cnt_q + CW'(1);
    assign burst_end = last || (cnt_d == CW'(MAX_BEATS));

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        mux_gate_cell u_cell (
            .a  (opnd_d[i]),
            .b  (b[i]),
            .op (op_d),
            .y  (fold_d[i])
        );
    end

`ifdef MUX_GATE_PARITY_EN
    logic par_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_AND;
            acc_q       <= '0;
            cnt_q       <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            out_beats_q <= '0;
`ifdef MUX_GATE_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            if (out_fire) out_valid_q <= 1'b0;
            if (in_fire) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!accum || last) begin
                            y_q         <= fold_d;
                            out_valid_q <= 1'b1;
                            out_beats_q <= CW'(1);
                            out_err_q   <= 1'b0;
`ifdef MUX_GATE_PARITY_EN
                            par_q       <= ^fold_d;
`endif
                        end else begin
                            acc_q   <= fold_d;
                            op_q    <= op_t'(op);
                            cnt_q   <= CW'(1);
                            state_q <= ST_ACC;
                        end
                    end
                    ST_ACC: begin
                        if (burst_end) begin
                            // A burst cut off at MAX_BEATS without last is flagged.
                            y_q         <= fold_d;
                            out_valid_q <= 1'b1;
                            out_beats_q <= cnt_d;
                            out_err_q   <= !last;
                            state_q     <= ST_IDLE;
`ifdef MUX_GATE_PARITY_EN
                            par_q       <= ^fold_d;
`endif
                        end else begin
                            acc_q <= fold_d;
                            cnt_q <= cnt_d;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign out_err   = out_err_q;
    assign out_beats = out_beats_q;
`ifdef MUX_GATE_PARITY_EN
    assign out_par   = par_q;
`endif

endmodule
